// File: rtl/dmac_apb_pkg.sv
// Shared types for the DMAC APB requester and the sequencer that feeds it.
// Holds the requester states, the bus widths and the command record.
package dmac_apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/dmac_apb_master_if.sv
// Command, APB and response channels of the DMAC APB requester.
// The master modport is the requester's view; slave is the view of whatever surrounds it.
interface dmac_apb_master_if #(
    parameter int ADDR_W = dmac_apb_pkg::APB_ADDR_W,
    parameter int DATA_W = dmac_apb_pkg::APB_DATA_W
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;

    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i;
    logic [DATA_W-1:0] prdata_i;
    logic              pslverr_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output cmd_ready_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
        input  pready_i, prdata_i, pslverr_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
        output pready_i, prdata_i, pslverr_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i
    );

endinterface

// File: rtl/dmac_apb_master.sv
// Turns one valid/ready command into one APB SETUP+ACCESS transfer and returns a response.
// Latency: accept cycle N, SETUP N+1, ACCESS N+2, response from N+3 with zero wait states.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, and pready stalls are aborted after TIMEOUT_CYCLES.
module dmac_apb_master
    import dmac_apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmac_apb_master_if.master    bus
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] rdata_done;

    assign bus.cmd_ready_o = (state == IDLE);

    // Read data is only returned for clean read completions.
    assign rdata_done = (!bus.pwrite_o && !bus.pslverr_i) ? bus.prdata_i : DATA_W'(0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid_i) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.pready_i || cnt == CNT_LAST) state_nxt = RESP;
            RESP:    if (bus.rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.psel_o        <= 1'b0;
            bus.penable_o     <= 1'b0;
            bus.paddr_o       <= '0;
            bus.pwrite_o      <= 1'b0;
            bus.pwdata_o      <= '0;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_timeout_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.psel_o    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            bus.penable_o <= (state_nxt == ACCESS);
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        bus.paddr_o  <= bus.cmd_addr_i;
                        bus.pwrite_o <= bus.cmd_write_i;
                        bus.pwdata_o <= bus.cmd_wdata_i;
                    end
                end
                SETUP: cnt <= '0;
                ACCESS: begin
                    if (bus.pready_i) begin
                        bus.rsp_valid_o   <= 1'b1;
                        bus.rsp_rdata_o   <= rdata_done;
                        bus.rsp_err_o     <= bus.pslverr_i;
                        bus.rsp_timeout_o <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        bus.rsp_valid_o   <= 1'b1;
                        bus.rsp_rdata_o   <= '0;
                        bus.rsp_err_o     <= 1'b1;
                        bus.rsp_timeout_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o   <= 1'b0;
                        bus.rsp_rdata_o   <= '0;
                        bus.rsp_err_o     <= 1'b0;
                        bus.rsp_timeout_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
